bram_stream_fifo: RTL and testbench

BRAM_STREAM_FIFO -- requirements
Module: bram_stream_fifo

---
 rtl/bram_stream_pkg.sv | 21 ++
 rtl/bram_stream_fifo_bram.sv | 26 ++
 rtl/bram_stream_fifo.sv | 121 ++++++++++++
 tb/tb_bram_stream_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
// Shared sizing helpers and output-queue operation encoding for the BRAM-backed
// stream FIFO.
package bram_stream_pkg;

  function automatic int depth_of(input int addr);
    return 1 << addr;
  endfunction

  // storage depth plus the in-flight read and two output-queue slots
  function automatic int count_width(input int addr);
    return addr + 2;
  endfunction

  typedef enum logic [1:0] {
    OQ_HOLD,
    OQ_POP,
    OQ_APPEND,
    OQ_SWAP
  } oq_op_e;

endpackage

// File: rtl/bram_stream_fifo_bram.sv
// Simple dual-port block RAM: both ports synchronous, one-cycle registered read on port B.
module DualPortBRAM
  import bram_stream_pkg::*;
#(
  parameter int DATA = 72,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            a_wr,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_din,
  input  logic            b_wr,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_din,
  output logic [DATA-1:0] b_dout
);

  logic [DATA-1:0] mem [depth_of(ADDR)];

  always_ff @(posedge clk) begin
    if (a_wr) mem[a_addr] <= a_din;
    if (b_wr) mem[b_addr] <= b_din;
    b_dout <= mem[b_addr];
  end

endmodule

// File: rtl/bram_stream_fifo.sv
// Stream FIFO with BRAM storage and a 2-entry output register queue that hides
// the one-cycle BRAM read latency, giving full throughput with registered outputs.
module bram_stream_fifo
  import bram_stream_pkg::*;
#(
  parameter int DATA = 72,
  parameter int ADDR = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA-1:0]               in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA-1:0]               out_data,
  output logic [count_width(ADDR)-1:0]  count
);

  localparam int CW = count_width(ADDR);
  localparam logic [ADDR:0] MEM_FULL = (ADDR+1)'(depth_of(ADDR));

  logic [ADDR-1:0] wr_ptr;
  logic [ADDR-1:0] rd_ptr;
  logic [ADDR:0]   mem_count;
  logic            rd_inflight;
  logic [1:0]      ob_count;
  logic [DATA-1:0] ob0;
  logic [DATA-1:0] ob1;
  logic [DATA-1:0] b_dout;
  logic            push;
  logic            pop;
  logic            rd_issue;
  logic [2:0]      ob_room;
  oq_op_e          oq_op;

  assign in_ready  = (mem_count < MEM_FULL) && !rst;
  assign out_valid = (ob_count != 2'd0);
  assign out_data  = ob0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Output-queue occupancy next cycle, counting the word already in flight;
  // a new read is only issued if it is guaranteed a slot when it lands.
  assign ob_room  = {1'b0, ob_count} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_issue = (mem_count != '0) && (ob_room < 3'd2);

  assign count = CW'(mem_count) + CW'(rd_inflight) + CW'(ob_count);

  // Write slot is always free while in_ready, and the read slot is always
  // occupied, so the two ports never touch the same address.
  DualPortBRAM #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_bram (
    .clk    (clk),
    .a_wr   (push),
    .a_addr (wr_ptr),
    .a_din  (in_data),
    .b_wr   (1'b0),
    .b_addr (rd_ptr),
    .b_din  ('0),
    .b_dout (b_dout)
  );

  always_comb begin
    oq_op = OQ_HOLD;
    case ({pop, rd_inflight})
      2'b10:   oq_op = OQ_POP;
      2'b01:   oq_op = OQ_APPEND;
      2'b11:   oq_op = OQ_SWAP;
      default: oq_op = OQ_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      rd_inflight <= 1'b0;
      ob_count    <= 2'd0;
      ob0         <= '0;
      ob1         <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + ADDR'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR'(1);

      case ({push, rd_issue})
        2'b10:   mem_count <= mem_count + (ADDR+1)'(1);
        2'b01:   mem_count <= mem_count - (ADDR+1)'(1);
        default: mem_count <= mem_count;
      endcase

      rd_inflight <= rd_issue;

      case (oq_op)
        OQ_POP: begin
          ob0      <= ob1;
          ob_count <= ob_count - 2'd1;
        end
        OQ_APPEND: begin
          if (ob_count == 2'd0) ob0 <= b_dout;
          else                  ob1 <= b_dout;
          ob_count <= ob_count + 2'd1;
        end
        OQ_SWAP: begin
          // count unchanged: head leaves, returning word joins the tail
          if (ob_count == 2'd2) begin
            ob0 <= ob1;
            ob1 <= b_dout;
          end else begin
            ob0 <= b_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Bench for bram_stream_fifo: three instances (ADDR 10/2/3) share stimulus; sel picks
// the one under check. Scoreboard queue holds accepted words in order.
module tb_bram_stream_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [71:0] in_data = '0;

  logic        ir_m, ov_m, ir_2, ov_2, ir_3, ov_3;
  logic [71:0] od_m, od_2, od_3;
  logic [11:0] cnt_m;
  logic [3:0]  cnt_2;
  logic [4:0]  cnt_3;

  bram_stream_fifo #(.DATA(72), .ADDR(10)) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_m), .in_data(in_data),
    .out_valid(ov_m), .out_ready(out_ready), .out_data(od_m), .count(cnt_m));
  bram_stream_fifo #(.DATA(72), .ADDR(2)) u_a2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_2), .in_data(in_data),
    .out_valid(ov_2), .out_ready(out_ready), .out_data(od_2), .count(cnt_2));
  bram_stream_fifo #(.DATA(72), .ADDR(3)) u_a3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_3), .in_data(in_data),
    .out_valid(ov_3), .out_ready(out_ready), .out_data(od_3), .count(cnt_3));

  int          sel = 0;
  logic        o_ir, o_ov;
  logic [71:0] o_od;
  logic [11:0] o_cnt;

  always_comb begin
    o_ir = ir_m; o_ov = ov_m; o_od = od_m; o_cnt = cnt_m;
    case (sel)
      1: begin o_ir = ir_2; o_ov = ov_2; o_od = od_2; o_cnt = 12'(cnt_2); end
      2: begin o_ir = ir_3; o_ov = ov_3; o_od = od_3; o_cnt = 12'(cnt_3); end
      default: ;
    endcase
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [71:0] sb[$];
  logic        last_acc;
  int          n_pop;
  int          cyc = 0;
  int          first_pop, last_pop;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive one cycle of inputs, update the
  // scoreboard from the handshake, step past the next edge.
  task automatic tick(input logic r, input logic iv, input logic [71:0] d, input logic ordy);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    #2;
    if (o_ov && ordy) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pop_unexpected: got %0h expected no word", o_od);
      end else begin
        chk("pop_data", o_od, sb.pop_front());
      end
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    last_acc = iv && o_ir;
    if (last_acc) sb.push_back(d);
    @(posedge clk); #1;
    cyc++;
    if (r) sb.delete();
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    n_pop = 0; first_pop = -1; last_pop = -1;
  endtask

  task automatic drain(input string name, input int exp_pops);
    n_pop = 0;
    for (int t = 0; t < 100 && sb.size() > 0; t++) tick(1'b0, 1'b0, '0, 1'b1);
    chk({name, "_pops"}, 72'(n_pop), 72'(exp_pops));
    chk({name, "_count0"}, 72'(o_cnt), 72'(0));
  endtask

  typedef struct {
    logic        r, iv;
    logic [71:0] d;
    logic        ordy;
    logic        e_ov;
    logic [71:0] e_od;
    logic [11:0] e_cnt;
    logic        e_ir;
  } vec_t;

  vec_t vt[13];

  initial begin
    int          k, maxcnt;
    logic [71:0] d;
    logic        iv, ordy;

    // expected values are those observed just after the edge consuming the row
    vt[0]  = '{1'b1, 1'b0, 72'h0,  1'b0, 1'b0, 72'h0,  12'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 72'h0,  1'b0, 1'b0, 72'h0,  12'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 72'h0,  1'b0, 1'b0, 72'h0,  12'd0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 72'hA5, 1'b0, 1'b0, 72'h0,  12'd1, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 72'h0,  1'b0, 1'b0, 72'h0,  12'd1, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 72'h0,  1'b0, 1'b1, 72'hA5, 12'd1, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 72'h3C, 1'b1, 1'b0, 72'h0,  12'd1, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 72'h0,  1'b1, 1'b0, 72'h0,  12'd1, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 72'h0,  1'b1, 1'b1, 72'h3C, 12'd1, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 72'h0,  1'b1, 1'b0, 72'h0,  12'd0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 72'h11, 1'b0, 1'b0, 72'h0,  12'd1, 1'b1};
    vt[11] = '{1'b1, 1'b0, 72'h0,  1'b0, 1'b0, 72'h0,  12'd0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 72'h0,  1'b0, 1'b0, 72'h0,  12'd0, 1'b1};

    @(posedge clk); #1;
    sel = 0; n_pop = 0; first_pop = -1; last_pop = -1;

    // table: reset state, single-word latency, pop/push overlap, mid-run reset
    for (int i = 0; i < 13; i++) begin
      tick(vt[i].r, vt[i].iv, vt[i].d, vt[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), 72'(o_ov), 72'(vt[i].e_ov));
      chk($sformatf("vec%0d_count", i), 72'(o_cnt), 72'(vt[i].e_cnt));
      chk($sformatf("vec%0d_in_ready", i), 72'(o_ir), 72'(vt[i].e_ir));
      if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), o_od, vt[i].e_od);
    end

    // ADDR=2 fill under backpressure: 4 in storage + 2 in output queue
    sel = 1;
    do_reset();
    k = 1;
    for (int t = 0; t < 20 && k <= 8; t++) begin
      tick(1'b0, 1'b1, 72'(k), 1'b0);
      if (last_acc) k++;
    end
    chk("a2_accepted", 72'(k - 1), 72'(6));
    chk("a2_in_ready", 72'(o_ir), 72'(0));
    chk("a2_count", 72'(o_cnt), 72'(6));
    drain("a2_drain", 6);

    // continuous streaming at full rate
    sel = 0;
    do_reset();
    k = 1; maxcnt = 0;
    for (int t = 0; t < 300 && n_pop < 100; t++) begin
      tick(1'b0, k <= 100, 72'(k), 1'b1);
      if (last_acc) k++;
      if (int'(o_cnt) > maxcnt) maxcnt = int'(o_cnt);
    end
    chk("stream_pops", 72'(n_pop), 72'(100));
    chk("stream_max_count_le3", 72'(maxcnt > 3), 72'(0));
    chk("stream_back_to_back", 72'(last_pop - first_pop), 72'(99));

    // reset while count=5 and a read is in flight
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 72'h100 + 72'(i), 1'b0);
    tick(1'b0, 1'b1, 72'h105, 1'b1);
    chk("rst_pre_count", 72'(o_cnt), 72'(5));
    tick(1'b1, 1'b0, '0, 1'b0);
    chk("rst_out_valid", 72'(o_ov), 72'(0));
    chk("rst_count", 72'(o_cnt), 72'(0));
    tick(1'b0, 1'b0, '0, 1'b0);
    chk("post_rst_out_valid", 72'(o_ov), 72'(0));
    chk("post_rst_count", 72'(o_cnt), 72'(0));
    chk("post_rst_in_ready", 72'(o_ir), 72'(1));
    tick(1'b0, 1'b1, 72'h77, 1'b0);
    tick(1'b0, 1'b1, 72'h78, 1'b0);
    drain("post_rst_drain", 2);

    // head held stable under backpressure while pushes continue
    do_reset();
    tick(1'b0, 1'b1, 72'hE0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 72'hE1 + 72'(i), 1'b0);
      chk("hold_out_valid", 72'(o_ov), 72'(1));
      chk("hold_out_data", o_od, sb[0]);
    end
    drain("hold_drain", 11);

    // random handshakes on ADDR=3, many pointer wraps
    sel = 2;
    do_reset();
    k = 0;
    for (int t = 0; t < 80000 && n_pop < 10000; t++) begin
      iv   = (k < 10000) && ($urandom_range(1) == 1);
      ordy = ($urandom_range(1) == 1);
      d    = {$urandom(), $urandom(), 8'(k)};
      tick(1'b0, iv, d, ordy);
      if (last_acc) k++;
      chk("rand_count", 72'(o_cnt), 72'(sb.size()));
    end
    chk("rand_pops", 72'(n_pop), 72'(10000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
